// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER multicycle control unit.
package otter_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    INTR  = 3'd4
  } cu_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  // Opcodes that write a result to the register file in EXEC.
  function automatic logic writes_rf(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL)   || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/otter_intr_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt line with a
// rising-edge detector producing a single-cycle pulse.
module otter_intr_sync
  import otter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER RV32I core. Optional retired-instruction
// counter is built when OTTER_CU_INSTRET_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  ir6_0,
  input  logic [2:0]  ir14_12,
  input  logic        intr,
  input  logic        csr_mie,
  output logic        rst_out,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic        csr_we,
  output logic        int_taken,
  output logic        mret_exec
`ifdef OTTER_CU_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  cu_state_t state_q, state_d;
  logic      int_pend_q, int_pend_d;
  logic      intr_pulse;
  logic      boundary;

  otter_intr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_intr_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .async_i (intr),
    .pulse_o (intr_pulse)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= INIT;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
    end
  end

  // A new interrupt edge outranks the clear issued when leaving INTR.
  always_comb begin
    int_pend_d = int_pend_q;
    if (intr_pulse) begin
      int_pend_d = 1'b1;
    end else if (state_q == INTR) begin
      int_pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    boundary  = 1'b0;
    rst_out   = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    case (state_q)
      INIT: begin
        rst_out = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = EXEC;
      end
      EXEC: begin
        if (ir6_0 == OP_LOAD) begin
          mem_rden2 = 1'b1;
          state_d   = WB;
        end else begin
          pc_write = 1'b1;
          boundary = 1'b1;
          if (ir6_0 == OP_STORE) begin
            mem_we2 = 1'b1;
          end else if (writes_rf(ir6_0)) begin
            reg_write = 1'b1;
          end else if (ir6_0 == OP_SYS) begin
            if (ir14_12 == F3_MRET) begin
              mret_exec = 1'b1;
            end else if (ir14_12 == F3_CSRRW) begin
              csr_we    = 1'b1;
              reg_write = 1'b1;
            end
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        boundary  = 1'b1;
      end
      INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Traps are only taken between instructions.
    if (boundary) begin
      state_d = (int_pend_q && csr_mie) ? INTR : FETCH;
    end
  end

`ifdef OTTER_CU_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instret_q <= 64'd0;
    end else if (boundary) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm; instret checks are built when
// OTTER_CU_INSTRET_EN is defined.
`timescale 1ns/1ps
module tb_otter_cu_fsm;

  // Output vector: {rst_out,pc_write,reg_write,mem_rden1,mem_rden2,mem_we2,csr_we,int_taken,mret_exec}
  localparam logic [8:0] E_INIT  = 9'b1_0000_0000;
  localparam logic [8:0] E_FETCH = 9'b0_0010_0000;
  localparam logic [8:0] E_PC    = 9'b0_1000_0000;
  localparam logic [8:0] E_PCRF  = 9'b0_1100_0000;
  localparam logic [8:0] E_LOAD  = 9'b0_0001_0000;
  localparam logic [8:0] E_STORE = 9'b0_1000_1000;
  localparam logic [8:0] E_MRET  = 9'b0_1000_0001;
  localparam logic [8:0] E_CSR   = 9'b0_1100_0100;
  localparam logic [8:0] E_INTR  = 9'b0_1000_0010;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       intr;
  logic       csr_mie;
  logic       rst_out, pc_write, reg_write, mem_rden1, mem_rden2;
  logic       mem_we2, csr_we, int_taken, mret_exec;
`ifdef OTTER_CU_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] model_instret;
`endif

  logic [8:0] obs;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] exp;
    string      tag;
    logic       drv;
    logic [6:0] op;
    logic [2:0] f3;
  } exp_t;

  exp_t sb[$];

  otter_cu_fsm #(.SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ir6_0     (ir6_0),
    .ir14_12   (ir14_12),
    .intr      (intr),
    .csr_mie   (csr_mie),
    .rst_out   (rst_out),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_rden1 (mem_rden1),
    .mem_rden2 (mem_rden2),
    .mem_we2   (mem_we2),
    .csr_we    (csr_we),
    .int_taken (int_taken),
    .mret_exec (mret_exec)
`ifdef OTTER_CU_INSTRET_EN
    ,
    .instret   (instret)
`endif
  );

  always #5 CLK = ~CLK;

  assign obs = {rst_out, pc_write, reg_write, mem_rden1, mem_rden2,
                mem_we2, csr_we, int_taken, mret_exec};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [8:0] exec_exp(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return E_LOAD;
      7'b0100011: return E_STORE;
      7'b1100011: return E_PC;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return E_PCRF;
      7'b1110011: begin
        if (f3 == 3'b000) return E_MRET;
        if (f3 == 3'b001) return E_CSR;
        return E_PC;
      end
      default: return E_PC;
    endcase
  endfunction

  // Queues the full cycle sequence of one instruction, starting from FETCH.
  task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input string name);
    exp_t e;
    e.exp = E_FETCH; e.tag = {name, "_fetch"}; e.drv = 1'b1; e.op = op; e.f3 = f3;
    sb.push_back(e);
    e.exp = exec_exp(op, f3); e.tag = {name, "_exec"}; e.drv = 1'b0;
    sb.push_back(e);
    if (op == 7'b0000011) begin
      e.exp = E_PCRF; e.tag = {name, "_wb"};
      sb.push_back(e);
    end
`ifdef OTTER_CU_INSTRET_EN
    model_instret++;
`endif
  endtask

  task automatic push_intr();
    exp_t e;
    e.exp = E_INTR; e.tag = "intr_state"; e.drv = 1'b0; e.op = 7'd0; e.f3 = 3'd0;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (obs !== E_INIT) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b want %b", obs, E_INIT);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL reset_to_fetch: got %b want %b", obs, E_FETCH);
    end
`ifdef OTTER_CU_INSTRET_EN
    model_instret = 64'd0;
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("[TB] FAIL instret_reset: got %0d want 0", instret);
    end
`endif
  endtask

  task automatic test_rtype();
    exp_t e;
    push_instr(7'b0110011, 3'b000, "add");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %b want %b", e.tag, obs, e.exp);
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      @(negedge CLK);
    end
`ifdef OTTER_CU_INSTRET_EN
    checks++;
    if (instret !== model_instret) begin
      errors++;
      $display("[TB] FAIL instret_rtype: got %0d want %0d", instret, model_instret);
    end
`endif
  endtask

  task automatic test_load();
    exp_t e;
    push_instr(7'b0000011, 3'b010, "lw");
    push_instr(7'b0010011, 3'b000, "addi_after_lw");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %b want %b", e.tag, obs, e.exp);
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      @(negedge CLK);
    end
`ifdef OTTER_CU_INSTRET_EN
    checks++;
    if (instret !== model_instret) begin
      errors++;
      $display("[TB] FAIL instret_load: got %0d want %0d", instret, model_instret);
    end
`endif
  endtask

  task automatic test_intr();
    exp_t e;
    int   idx;
    csr_mie = 1'b1;
    idx = 0;
    repeat (3) push_instr(7'b0110011, 3'b000, "add_int");
    push_intr();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s idx %0d: got %b want %b", e.tag, idx, obs, e.exp);
      end
      if (idx == 2) begin
        checks++;
        if (dut.int_pend_q !== 1'b0) begin
          errors++;
          $display("[TB] FAIL int_pend_early: got %b want 0", dut.int_pend_q);
        end
      end
      if (idx == 4) begin
        checks++;
        if (dut.int_pend_q !== 1'b1) begin
          errors++;
          $display("[TB] FAIL int_pend_set: got %b want 1", dut.int_pend_q);
        end
        intr = 1'b0;
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      if (idx == 1) intr = 1'b1;
      @(negedge CLK);
      idx++;
    end
    checks++;
    if (dut.int_pend_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL int_pend_clear: got %b want 0", dut.int_pend_q);
    end
  endtask

  task automatic test_mie_gate();
    exp_t e;
    int   idx;
    csr_mie = 1'b0;
    idx = 0;
    repeat (5) push_instr(7'b0010011, 3'b000, "addi_masked");
    push_intr();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s idx %0d: got %b want %b", e.tag, idx, obs, e.exp);
      end
      if (idx == 4) intr = 1'b0;
      if (idx == 8) begin
        checks++;
        if (dut.int_pend_q !== 1'b1) begin
          errors++;
          $display("[TB] FAIL int_pend_masked: got %b want 1", dut.int_pend_q);
        end
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      if (idx == 1) intr = 1'b1;
      if (idx == 9) csr_mie = 1'b1;
      @(negedge CLK);
      idx++;
    end
  endtask

  task automatic test_system();
    exp_t e;
    push_instr(7'b1110011, 3'b000, "mret");
    push_instr(7'b1110011, 3'b001, "csrrw");
    push_instr(7'b1110011, 3'b010, "csrrs_nop");
    push_instr(7'b1111111, 3'b000, "illegal_nop");
    push_instr(7'b0100011, 3'b010, "sw");
    push_instr(7'b1100011, 3'b000, "beq");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %b want %b", e.tag, obs, e.exp);
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [6:0] ops [13];
    logic [2:0] f3s [13];
    int         k;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011,
            7'b1110011, 7'b1110011, 7'b0001111};
    f3s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd2, 3'd2, 3'd1, 3'd0,
            3'd1, 3'd5, 3'd0};
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 12);
      push_instr(ops[k], f3s[k], "b2b");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s op %b: got %b want %b", e.tag, ir6_0, obs, e.exp);
      end
      if (e.drv) begin ir6_0 = e.op; ir14_12 = e.f3; end
      @(negedge CLK);
    end
`ifdef OTTER_CU_INSTRET_EN
    checks++;
    if (instret !== model_instret) begin
      errors++;
      $display("[TB] FAIL instret_b2b: got %0d want %0d", instret, model_instret);
    end
`endif
  endtask

  task automatic test_reset_mid();
    ir6_0 = 7'b0000011; ir14_12 = 3'b010;
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL rmid_fetch: got %b want %b", obs, E_FETCH);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (obs !== E_PCRF) begin
      errors++;
      $display("[TB] FAIL rmid_wb: got %b want %b", obs, E_PCRF);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (reg_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_reg_write_drop: got %b want 0", reg_write);
    end
    checks++;
    if (obs !== E_INIT) begin
      errors++;
      $display("[TB] FAIL rmid_init: got %b want %b", obs, E_INIT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL rmid_refetch: got %b want %b", obs, E_FETCH);
    end
`ifdef OTTER_CU_INSTRET_EN
    model_instret = 64'd0;
    checks++;
    if (instret !== model_instret) begin
      errors++;
      $display("[TB] FAIL instret_rmid: got %0d want 0", instret);
    end
`endif
  endtask

  initial begin
    RST_N   = 1'b0;
    ir6_0   = 7'd0;
    ir14_12 = 3'd0;
    intr    = 1'b0;
    csr_mie = 1'b0;
`ifdef OTTER_CU_INSTRET_EN
    model_instret = 64'd0;
`endif
    test_reset();
    test_rtype();
    test_load();
    test_intr();
    test_mie_gate();
    test_system();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
